// File: rtl/acc_arb_pkg.sv
// rtl/acc_arb_pkg.sv - shared types and widths for the accelerator memory arbiter
package acc_arb_pkg;

    localparam int NUM_CORES_DEF = 4;
    localparam int ADDR_W        = 16;
    localparam int DATA_W        = 32;
    localparam int LINE_W        = 512;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_WR_WAIT = 2'd2,
        ST_RESP    = 2'd3
    } arb_state_e;

endpackage

// File: rtl/acc_rr_pick.sv
// rtl/acc_rr_pick.sv - combinational circular priority pick starting at rr_ptr
module acc_rr_pick
    import acc_arb_pkg::*;
#(
    parameter int N     = NUM_CORES_DEF,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     pending_i,
    input  logic [IDX_W-1:0] rr_ptr_i,
    output logic [IDX_W-1:0] grant_o,
    output logic             any_o
);

    logic [N-1:0] rot;
    logic [IDX_W:0] sum;

    // Rotating the pending vector puts rr_ptr at bit 0, so the lowest set bit is the winner.
    always_comb begin
        rot     = N'({pending_i, pending_i} >> rr_ptr_i);
        any_o   = 1'b0;
        sum     = '0;
        grant_o = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                sum   = {1'b0, rr_ptr_i} + (IDX_W + 1)'(i);
                any_o = 1'b1;
            end
        end
        if (sum >= (IDX_W + 1)'(N)) begin
            sum = sum - (IDX_W + 1)'(N);
        end
        grant_o = sum[IDX_W-1:0];
    end

endmodule

// File: rtl/acc_mem_arbiter.sv
// rtl/acc_mem_arbiter.sv - round-robin arbiter of N accelerator cores onto one memory port
module acc_mem_arbiter
    import acc_arb_pkg::*;
#(
    parameter int NUM_CORES = NUM_CORES_DEF
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_CORES-1:0]        core_rd_en,
    input  logic [ADDR_W*NUM_CORES-1:0] core_rd_addr,
    input  logic [NUM_CORES-1:0]        core_wr_en,
    input  logic [ADDR_W*NUM_CORES-1:0] core_wr_addr,
    input  logic [DATA_W*NUM_CORES-1:0] core_wr_data,
    output logic [LINE_W-1:0]           core_rd_data,
    output logic [NUM_CORES-1:0]        core_rd_valid,
    output logic [NUM_CORES-1:0]        core_wr_done,
    output logic                        mem_acc_read_en,
    output logic [ADDR_W-1:0]           mem_acc_read_addr,
    output logic                        mem_acc_write_en,
    output logic [ADDR_W-1:0]           mem_acc_write_addr,
    output logic [DATA_W-1:0]           mem_acc_write_data,
    input  logic [LINE_W-1:0]           mem_acc_read_data,
    input  logic                        mem_acc_read_data_valid,
    input  logic                        mem_acc_write_done,
    output logic                        busy
);

    localparam int IDX_W = $clog2(NUM_CORES);

    arb_state_e           state_q, state_d;
    logic [IDX_W-1:0]     grant_q, grant_d;
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic                 rd_en_q, rd_en_d;
    logic                 wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]    rd_addr_q, rd_addr_d;
    logic [ADDR_W-1:0]    wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]    wr_data_q, wr_data_d;
    logic [LINE_W-1:0]    rd_data_q, rd_data_d;
    logic [NUM_CORES-1:0] rd_valid_q, rd_valid_d;
    logic [NUM_CORES-1:0] wr_done_q, wr_done_d;

    logic [IDX_W-1:0]     pick_idx;
    logic                 any_pending;
    logic                 sel_rd_en;
    logic [ADDR_W-1:0]    sel_rd_addr;
    logic [ADDR_W-1:0]    sel_wr_addr;
    logic [DATA_W-1:0]    sel_wr_data;

    acc_rr_pick #(
        .N     (NUM_CORES),
        .IDX_W (IDX_W)
    ) u_pick (
        .pending_i (core_rd_en | core_wr_en),
        .rr_ptr_i  (rr_ptr_q),
        .grant_o   (pick_idx),
        .any_o     (any_pending)
    );

    always_comb begin
        sel_rd_en   = 1'b0;
        sel_rd_addr = '0;
        sel_wr_addr = '0;
        sel_wr_data = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            if (pick_idx == IDX_W'(k)) begin
                sel_rd_en   = core_rd_en[k];
                sel_rd_addr = core_rd_addr[k*ADDR_W +: ADDR_W];
                sel_wr_addr = core_wr_addr[k*ADDR_W +: ADDR_W];
                sel_wr_data = core_wr_data[k*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_ptr_d   = rr_ptr_q;
        rd_en_d    = rd_en_q;
        wr_en_d    = wr_en_q;
        rd_addr_d  = rd_addr_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = '0;
        wr_done_d  = '0;
        case (state_q)
            ST_IDLE: begin
                if (any_pending) begin
                    grant_d = pick_idx;
                    // A core asking for both is served its read now; the write re-arbitrates later.
                    if (sel_rd_en) begin
                        state_d   = ST_RD_WAIT;
                        rd_en_d   = 1'b1;
                        rd_addr_d = sel_rd_addr;
                    end else begin
                        state_d   = ST_WR_WAIT;
                        wr_en_d   = 1'b1;
                        wr_addr_d = sel_wr_addr;
                        wr_data_d = sel_wr_data;
                    end
                end
            end
            ST_RD_WAIT: begin
                if (mem_acc_read_data_valid) begin
                    rd_data_d  = mem_acc_read_data;
                    rd_valid_d = NUM_CORES'(1) << grant_q;
                    rd_en_d    = 1'b0;
                    state_d    = ST_RESP;
                end
            end
            ST_WR_WAIT: begin
                if (mem_acc_write_done) begin
                    wr_done_d = NUM_CORES'(1) << grant_q;
                    wr_en_d   = 1'b0;
                    state_d   = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d  = ST_IDLE;
                rr_ptr_d = (grant_q == IDX_W'(NUM_CORES - 1)) ? '0 : grant_q + 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            rd_en_q    <= 1'b0;
            wr_en_q    <= 1'b0;
            rd_addr_q  <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= '0;
            wr_done_q  <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            rd_en_q    <= rd_en_d;
            wr_en_q    <= wr_en_d;
            rd_addr_q  <= rd_addr_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            wr_done_q  <= wr_done_d;
        end
    end

    assign core_rd_data       = rd_data_q;
    assign core_rd_valid      = rd_valid_q;
    assign core_wr_done       = wr_done_q;
    assign mem_acc_read_en    = rd_en_q;
    assign mem_acc_read_addr  = rd_addr_q;
    assign mem_acc_write_en   = wr_en_q;
    assign mem_acc_write_addr = wr_addr_q;
    assign mem_acc_write_data = wr_data_q;
    assign busy               = (state_q != ST_IDLE);

endmodule

// File: tb/tb_acc_mem_arbiter.sv
// tb/tb_acc_mem_arbiter.sv - directed table and sequence checks for acc_mem_arbiter
module tb_acc_mem_arbiter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   rd_en, wr_en;
    logic [63:0]  rd_addr, wr_addr;
    logic [127:0] wr_data;
    logic [511:0] rd_data;
    logic [3:0]   rd_valid, wr_done;
    logic         m_ren, m_wen;
    logic [15:0]  m_raddr, m_waddr;
    logic [31:0]  m_wdata;
    logic [511:0] m_rdata;
    logic         m_rvalid, m_wdone;
    logic         busy;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    acc_mem_arbiter #(.NUM_CORES(4)) dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .core_rd_en              (rd_en),
        .core_rd_addr            (rd_addr),
        .core_wr_en              (wr_en),
        .core_wr_addr            (wr_addr),
        .core_wr_data            (wr_data),
        .core_rd_data            (rd_data),
        .core_rd_valid           (rd_valid),
        .core_wr_done            (wr_done),
        .mem_acc_read_en         (m_ren),
        .mem_acc_read_addr       (m_raddr),
        .mem_acc_write_en        (m_wen),
        .mem_acc_write_addr      (m_waddr),
        .mem_acc_write_data      (m_wdata),
        .mem_acc_read_data       (m_rdata),
        .mem_acc_read_data_valid (m_rvalid),
        .mem_acc_write_done      (m_wdone),
        .busy                    (busy)
    );

    typedef struct {
        logic [3:0]  rd_en;
        logic        mv;
        logic [7:0]  dbyte;
        logic        exp_ren;
        logic [15:0] exp_addr;
        logic [3:0]  exp_valid;
        logic        exp_busy;
        logic [7:0]  exp_byte;
    } vec_t;

    vec_t tbl [15];

    function automatic vec_t mk(input logic [3:0] r, input logic mv, input logic [7:0] db,
                                input logic er, input logic [15:0] ea, input logic [3:0] ev,
                                input logic eb, input logic [7:0] ey);
        vec_t v;
        v.rd_en = r; v.mv = mv; v.dbyte = db; v.exp_ren = er; v.exp_addr = ea;
        v.exp_valid = ev; v.exp_busy = eb; v.exp_byte = ey;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    initial begin
        tbl[0]  = mk(4'hF, 1'b0, 8'h00, 1'b1, 16'h0100, 4'b0000, 1'b1, 8'h00);
        tbl[1]  = mk(4'hF, 1'b1, 8'h11, 1'b0, 16'h0000, 4'b0001, 1'b1, 8'h11);
        tbl[2]  = mk(4'hF, 1'b0, 8'h00, 1'b0, 16'h0000, 4'b0000, 1'b0, 8'h11);
        tbl[3]  = mk(4'hF, 1'b0, 8'h00, 1'b1, 16'h0200, 4'b0000, 1'b1, 8'h11);
        tbl[4]  = mk(4'hF, 1'b1, 8'h22, 1'b0, 16'h0000, 4'b0010, 1'b1, 8'h22);
        tbl[5]  = mk(4'hF, 1'b0, 8'h00, 1'b0, 16'h0000, 4'b0000, 1'b0, 8'h22);
        tbl[6]  = mk(4'hF, 1'b0, 8'h00, 1'b1, 16'h0300, 4'b0000, 1'b1, 8'h22);
        tbl[7]  = mk(4'hF, 1'b1, 8'h33, 1'b0, 16'h0000, 4'b0100, 1'b1, 8'h33);
        tbl[8]  = mk(4'hF, 1'b0, 8'h00, 1'b0, 16'h0000, 4'b0000, 1'b0, 8'h33);
        tbl[9]  = mk(4'hF, 1'b0, 8'h00, 1'b1, 16'h0400, 4'b0000, 1'b1, 8'h33);
        tbl[10] = mk(4'hF, 1'b1, 8'h44, 1'b0, 16'h0000, 4'b1000, 1'b1, 8'h44);
        tbl[11] = mk(4'hF, 1'b0, 8'h00, 1'b0, 16'h0000, 4'b0000, 1'b0, 8'h44);
        tbl[12] = mk(4'hF, 1'b0, 8'h00, 1'b1, 16'h0100, 4'b0000, 1'b1, 8'h44);
        tbl[13] = mk(4'hF, 1'b1, 8'h55, 1'b0, 16'h0000, 4'b0001, 1'b1, 8'h55);
        tbl[14] = mk(4'hF, 1'b0, 8'h00, 1'b0, 16'h0000, 4'b0000, 1'b0, 8'h55);

        rst_n = 1'b0; rd_en = '0; wr_en = '0; rd_addr = '0; wr_addr = '0; wr_data = '0;
        m_rdata = '0; m_rvalid = 1'b0; m_wdone = 1'b0;
        tick(); tick();
        chk("rst busy", busy, 0);
        chk("rst ren", m_ren, 0);
        chk("rst wen", m_wen, 0);
        chk("rst raddr", m_raddr, 0);
        chk("rst valid", rd_valid, 0);
        chk("rst done", wr_done, 0);
        chk("rst rdata", rd_data, 0);

        // Round robin: all cores read continuously, zero memory wait.
        rd_addr = {16'h0400, 16'h0300, 16'h0200, 16'h0100};
        rst_n = 1'b1;
        for (int i = 0; i < 15; i++) begin
            rd_en = tbl[i].rd_en;
            m_rvalid = tbl[i].mv;
            m_rdata = {64{tbl[i].dbyte}};
            tick();
            chk($sformatf("row%0d ren", i), m_ren, tbl[i].exp_ren);
            if (tbl[i].exp_ren) chk($sformatf("row%0d raddr", i), m_raddr, tbl[i].exp_addr);
            chk($sformatf("row%0d valid", i), rd_valid, tbl[i].exp_valid);
            chk($sformatf("row%0d busy", i), busy, tbl[i].exp_busy);
            chk($sformatf("row%0d rdata", i), rd_data, {64{tbl[i].exp_byte}});
            chk($sformatf("row%0d wen", i), m_wen, 0);
            chk($sformatf("row%0d done", i), wr_done, 0);
        end

        // Single read with three cycles of memory latency.
        rd_en = 4'b0100; rd_addr[2*16 +: 16] = 16'h1000; m_rvalid = 1'b0;
        tick();
        chk("sr ren", m_ren, 1);
        chk("sr raddr", m_raddr, 16'h1000);
        tick(); tick();
        chk("sr hold ren", m_ren, 1);
        chk("sr hold valid", rd_valid, 0);
        m_rvalid = 1'b1; m_rdata = {64{8'hA5}};
        tick();
        chk("sr valid", rd_valid, 4'b0100);
        chk("sr rdata", rd_data, {64{8'hA5}});
        chk("sr ren off", m_ren, 0);
        rd_en = '0; m_rvalid = 1'b0; m_rdata = '0;
        tick();
        chk("sr valid once", rd_valid, 0);
        chk("sr idle", busy, 0);
        chk("sr rdata hold", rd_data, {64{8'hA5}});

        // Read over write within core 1.
        rd_en = 4'b0010; wr_en = 4'b0010;
        rd_addr[16 +: 16] = 16'h5000; wr_addr[16 +: 16] = 16'h5000; wr_data[32 +: 32] = 32'hDEADBEEF;
        tick();
        chk("rw ren", m_ren, 1);
        chk("rw wen first", m_wen, 0);
        chk("rw raddr", m_raddr, 16'h5000);
        m_rvalid = 1'b1; m_rdata = {64{8'h5A}};
        tick();
        chk("rw rvalid", rd_valid, 4'b0010);
        rd_en = '0; m_rvalid = 1'b0;
        tick();
        chk("rw idle", busy, 0);
        tick();
        chk("rw wen", m_wen, 1);
        chk("rw waddr", m_waddr, 16'h5000);
        chk("rw wdata", m_wdata, 32'hDEADBEEF);
        m_wdone = 1'b1;
        tick();
        chk("rw done", wr_done, 4'b0010);
        chk("rw wen off", m_wen, 0);
        chk("rw rdata kept", rd_data, {64{8'h5A}});
        wr_en = '0; m_wdone = 1'b0;
        tick();
        chk("rw done once", wr_done, 0);

        // Spurious write_done in IDLE and in RD_WAIT.
        m_wdone = 1'b1;
        tick();
        chk("sp idle busy", busy, 0);
        chk("sp idle done", wr_done, 0);
        m_wdone = 1'b0; rd_en = 4'b0001; rd_addr[15:0] = 16'h0ABC;
        tick();
        chk("sp ren", m_ren, 1);
        m_wdone = 1'b1;
        tick();
        chk("sp rw ren", m_ren, 1);
        chk("sp rw busy", busy, 1);
        chk("sp rw done", wr_done, 0);
        chk("sp rw valid", rd_valid, 0);
        m_wdone = 1'b0; m_rvalid = 1'b1; m_rdata = {64{8'h77}};
        tick();
        chk("sp valid", rd_valid, 4'b0001);
        rd_en = '0; m_rvalid = 1'b0;
        tick();

        // Core 3 drops its write request mid-transaction.
        wr_en = 4'b1000; wr_addr[48 +: 16] = 16'h3333; wr_data[96 +: 32] = 32'h12345678;
        tick();
        chk("dr wen", m_wen, 1);
        chk("dr waddr", m_waddr, 16'h3333);
        wr_en = '0;
        tick(); tick();
        chk("dr wen held", m_wen, 1);
        chk("dr wdata held", m_wdata, 32'h12345678);
        m_wdone = 1'b1;
        tick();
        chk("dr done", wr_done, 4'b1000);
        m_wdone = 1'b0;
        tick();
        chk("dr done once", wr_done, 0);
        tick();
        chk("dr no regrant", m_wen, 0);
        chk("dr idle", busy, 0);

        // Reset while a read is outstanding.
        rd_en = 4'b0001; rd_addr[15:0] = 16'h0C0C;
        tick();
        chk("rr ren", m_ren, 1);
        rst_n = 1'b0; m_rvalid = 1'b1; m_rdata = {64{8'hFF}};
        tick();
        chk("rr rst ren", m_ren, 0);
        chk("rr rst busy", busy, 0);
        chk("rr rst valid", rd_valid, 0);
        chk("rr rst rdata", rd_data, 0);
        rst_n = 1'b1; m_rvalid = 1'b0;
        tick();
        chk("rr regrant ren", m_ren, 1);
        chk("rr regrant addr", m_raddr, 16'h0C0C);
        chk("rr regrant valid", rd_valid, 0);
        m_rvalid = 1'b1; m_rdata = {64{8'h99}};
        tick();
        chk("rr valid", rd_valid, 4'b0001);
        chk("rr rdata", rd_data, {64{8'h99}});
        rd_en = '0; m_rvalid = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
